io_bus_master: RTL and testbench
================================

// Module: io_bus_master
// PURPOSE
//   CPU-side initiator for the 8-bit port I/O interface (registers: dir 0 = direction control, 1/2/3 = ports A/B/C).
//   Accepts one 32-bit load/store from the RISC-V core's data-memory stage.
//   Splits the access into per-byte IO transactions, one per enabled byte lane, and sequences the wr/rd strobes.
//   Gathers read bytes back into a 32-bit word and reports completion with a one-cycle ack.
// PARAMETERS
//   BASE_ADDR      32'h0000_1000  word-aligned base address of the IO window; one word wide, lane n -> dir n
//   STROBE_CYCLES  1              cycles io_wr_o/io_rd_o stay high per byte transaction; legal range 1..15
// PORTS
//   clk_i      in   1   single clock; all state changes on the rising edge
//   rst_ni     in   1   asynchronous reset, active low
//   req_i      in   1   core request; sampled only in IDLE
//   we_i       in   1   1 = store, 0 = load
//   addr_i     in   32  byte address; only addr_i[31:2] is compared
//   wdata_i    in   32  store data; byte n is sent to dir n
//   be_i       in   4   byte enables; bit n enables lane/dir n
//   rdata_o    out  32  load data; valid while ack_o is high
//   ack_o      out  1   one-cycle completion pulse
//   err_o      out  1   high together with ack_o when the address is outside the window
//   busy_o     out  1   high in every state except IDLE; the core stalls on it
//   io_dir_o   out  2   IO register select (dir)
//   io_data_o  out  8   byte written to the IO interface
//   io_wr_o    out  1   IO write strobe
//   io_rd_o    out  1   IO read strobe
//   io_data_i  in   8   byte returned by the IO interface (combinational on dir)
// BEHAVIOUR
//   Reset (async, rst_ni=0): state IDLE; all outputs 0; latched request, lane mask and read buffer cleared.
//   Reset is effective immediately. A reset mid-transaction drops strobes at once; lanes already written are not undone or retried.
//   States: IDLE, SETUP, STROBE, HOLD, ACK.
//   IDLE:
//     - On req_i=1, latch we/addr/wdata/be and clear the read buffer.
//     - Address miss (addr_i[31:2] != BASE_ADDR[31:2]) or be_i=0 -> ACK. On a miss, err_o=1 in ACK.
//     - Otherwise lane = lowest set bit of be -> SETUP.
//   SETUP, 1 cycle: io_dir_o=lane; io_data_o=wdata byte[lane] on stores, 0 on loads; strobes low.
//   STROBE, STROBE_CYCLES cycles:
//     - io_wr_o=we, io_rd_o=!we; dir and data held.
//     - An internal counter counts down from STROBE_CYCLES-1.
//     - On the last strobe cycle of a load, capture io_data_i into rdata byte[lane].
//   HOLD, 1 cycle: strobes low; dir/data held. Clear lane bit in mask.
//     - If mask is still non-zero: next lane = lowest remaining bit -> SETUP.
//     - If mask is empty -> ACK.
//   ACK, 1 cycle: ack_o=1; rdata_o=buffer. On loads, disabled lanes read 0. On stores, rdata_o=0. -> IDLE.
//   Latency from the req edge to ack_o high is k*(STROBE_CYCLES+2)+1 cycles, where k = number of enabled lanes.
//     - Example: 1 lane, STROBE_CYCLES=1 -> ack 4 cycles after acceptance.
//   busy_o=1 in SETUP, STROBE, HOLD and ACK. req_i is ignored while busy_o=1; the core holds or reissues it.
//   Back-to-back: the cycle after ACK is IDLE, so a new request is accepted at the earliest 1 cycle after ack_o.
//   io_wr_o and io_rd_o are never high together; both are 0 outside STROBE.
//   Lanes are processed in ascending order (dir 0 before 1, 2, 3).
//     - A word store therefore programs the direction register before the ports.
//   Outputs are registered: no combinational path from req_i or io_data_i to any output.
// TESTING
//   1. Reset mid-transaction: rst_ni low during a STROBE cycle
//      -> io_wr_o/io_rd_o = 0 in the same cycle; no ack; IDLE after release.
//   2. Store, addr=BASE, be=4'b0010, wdata=32'h0000_A500
//      -> one transaction dir=1, data=8'hA5; wr high 1 cycle; ack 4 cycles after req; err_o=0.
//   3. Load, be=4'b1111, IO returns 00/11/22/33 for dir 0/1/2/3
//      -> 4 rd strobes in order dir 0,1,2,3; rdata_o=32'h3322_1100; ack 13 cycles after req.
//   4. Store, addr=BASE+4, be=4'b1111
//      -> no strobes; ack_o and err_o high 1 cycle after acceptance; busy_o high for that one cycle.
//   5. Load, be=4'b1010, STROBE_CYCLES=3, IO returns 8'h5A on dir 1 and 8'hC3 on dir 3
//      -> rd high 3 cycles per lane; dir 1 then dir 3; rdata_o=32'hC300_5A00.
//   6. req_i held high across ACK
//      -> second transaction starts from IDLE the cycle after ack; no strobe overlap; req_i pulses during busy ignored.

Source files
------------

// File: rtl/io_bus_master_if.sv
// Core-side load/store handshake plus the 8-bit port I/O bus of io_bus_master.
// The master modport is the initiator's view; slave is the core/IO-device side.
interface io_bus_master_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  be_i;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic        err_o;
  logic        busy_o;
  logic [1:0]  io_dir_o;
  logic [7:0]  io_data_o;
  logic        io_wr_o;
  logic        io_rd_o;
  logic [7:0]  io_data_i;

  modport master (
    input  req_i, we_i, addr_i, wdata_i, be_i, io_data_i,
    output rdata_o, ack_o, err_o, busy_o, io_dir_o, io_data_o, io_wr_o, io_rd_o
  );

  modport slave (
    output req_i, we_i, addr_i, wdata_i, be_i, io_data_i,
    input  rdata_o, ack_o, err_o, busy_o, io_dir_o, io_data_o, io_wr_o, io_rd_o
  );
endinterface

// File: rtl/io_bus_master.sv
// Splits one 32-bit core load/store into per-byte port I/O transactions (lane n -> dir n),
// sequencing SETUP/STROBE/HOLD per enabled lane and returning a one-cycle ack.
module io_bus_master #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_1000,
  parameter int unsigned STROBE_CYCLES = 1
) (
  input logic             clk_i,
  input logic             rst_ni,
  io_bus_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, ACK} state_t;

  localparam logic [3:0] CNT_INIT = 4'(STROBE_CYCLES - 1);

  state_t      state_q, state_d;
  logic        we_q;
  logic        miss_q;
  logic [31:0] wdata_q;
  logic [31:0] rbuf_q;
  logic [3:0]  mask_q;
  logic [1:0]  lane_q;
  logic [3:0]  cnt_q;

  logic        hit;
  logic [3:0]  mask_rem;
  logic        unused_addr;

  logic [31:0] rdata_c;
  logic        ack_c, err_c, busy_c, wr_c, rd_c;
  logic [1:0]  dir_c;
  logic [7:0]  data_c;

  function automatic logic [1:0] lowest_lane(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] n);
    return w[8*n +: 8];
  endfunction

  // The window is one word wide, so the byte offset bits never take part in decode.
  assign hit         = (bus.addr_i[31:2] == BASE_ADDR[31:2]);
  assign unused_addr = ^bus.addr_i[1:0];
  assign mask_rem    = mask_q & ~(4'b0001 << lane_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_i) state_d = (!hit || bus.be_i == 4'b0000) ? ACK : SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  if (cnt_q == 4'd0) state_d = HOLD;
      HOLD:    state_d = (mask_rem != 4'b0000) ? SETUP : ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      miss_q  <= 1'b0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      mask_q  <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_i) begin
          we_q    <= bus.we_i;
          miss_q  <= !hit;
          wdata_q <= bus.wdata_i;
          mask_q  <= bus.be_i;
          lane_q  <= lowest_lane(bus.be_i);
          rbuf_q  <= '0;
        end
        SETUP: cnt_q <= CNT_INIT;
        // Read data is taken on the final strobe cycle, giving the device the full strobe width.
        STROBE: begin
          if (cnt_q != 4'd0)  cnt_q <= cnt_q - 4'd1;
          else if (!we_q)     rbuf_q[8*lane_q +: 8] <= bus.io_data_i;
        end
        HOLD: begin
          mask_q <= mask_rem;
          lane_q <= lowest_lane(mask_rem);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_c = '0;
    ack_c   = 1'b0;
    err_c   = 1'b0;
    busy_c  = (state_q != IDLE);
    wr_c    = 1'b0;
    rd_c    = 1'b0;
    dir_c   = '0;
    data_c  = '0;
    if (state_q == SETUP || state_q == STROBE || state_q == HOLD) begin
      dir_c  = lane_q;
      data_c = we_q ? lane_byte(wdata_q, lane_q) : 8'h00;
    end
    if (state_q == STROBE) begin
      wr_c = we_q;
      rd_c = !we_q;
    end
    if (state_q == ACK) begin
      ack_c   = 1'b1;
      err_c   = miss_q;
      rdata_c = we_q ? 32'h0 : rbuf_q;
    end
  end

  assign bus.rdata_o   = rdata_c;
  assign bus.ack_o     = ack_c;
  assign bus.err_o     = err_c;
  assign bus.busy_o    = busy_c;
  assign bus.io_wr_o   = wr_c;
  assign bus.io_rd_o   = rd_c;
  assign bus.io_dir_o  = dir_c;
  assign bus.io_data_o = data_c;

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master: two instances (1 and 3 strobe cycles) checked every cycle
// against a transaction-level trace model, plus directed literal expectations.
module tb_io_bus_master;
  localparam logic [31:0] BASE = 32'h0000_1000;

  typedef struct packed {
    logic        busy;
    logic        wr;
    logic        rd;
    logic        ack;
    logic        err;
    logic [1:0]  dir;
    logic [7:0]  data;
    logic [31:0] rdata;
  } obs_t;

  typedef struct packed {
    obs_t o;
    logic chk_dd;
    logic chk_rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req[2];
  logic        we[2];
  logic [31:0] addr[2];
  logic [31:0] wdata[2];
  logic [3:0]  be[2];
  logic [7:0]  io_mem[2][4];
  obs_t        obs[2];

  exp_t expq0[$];
  exp_t expq1[$];

  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;
  int   acc_cyc[2];
  int   ack_cyc[2];
  logic [31:0] ack_rdata[2];
  logic        ack_err[2];
  int   wr_cnt[2];
  int   rd_cnt[2];
  logic [31:0] rd_log[2];
  logic [9:0]  last_io[2];

  io_bus_master_if bus0();
  io_bus_master_if bus1();

  assign bus0.req_i     = req[0];
  assign bus0.we_i      = we[0];
  assign bus0.addr_i    = addr[0];
  assign bus0.wdata_i   = wdata[0];
  assign bus0.be_i      = be[0];
  assign bus0.io_data_i = io_mem[0][bus0.io_dir_o];
  assign bus1.req_i     = req[1];
  assign bus1.we_i      = we[1];
  assign bus1.addr_i    = addr[1];
  assign bus1.wdata_i   = wdata[1];
  assign bus1.be_i      = be[1];
  assign bus1.io_data_i = io_mem[1][bus1.io_dir_o];

  assign obs[0] = {bus0.busy_o, bus0.io_wr_o, bus0.io_rd_o, bus0.ack_o, bus0.err_o,
                   bus0.io_dir_o, bus0.io_data_o, bus0.rdata_o};
  assign obs[1] = {bus1.busy_o, bus1.io_wr_o, bus1.io_rd_o, bus1.ack_o, bus1.err_o,
                   bus1.io_dir_o, bus1.io_data_o, bus1.rdata_o};

  io_bus_master #(.BASE_ADDR(BASE), .STROBE_CYCLES(1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus0.master));
  io_bus_master #(.BASE_ADDR(BASE), .STROBE_CYCLES(3)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus1.master));

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic void push_exp(input int k, input exp_t e);
    if (k == 0) expq0.push_back(e);
    else        expq1.push_back(e);
  endfunction

  // Expected per-cycle trace of one accepted request, starting the cycle after acceptance.
  function automatic int push_model(input int k, input logic w, input logic [31:0] a,
                                    input logic [31:0] d, input logic [3:0] b);
    exp_t        e;
    int          len = 0;
    int          s   = (k == 0) ? 1 : 3;
    logic [31:0] rexp = '0;
    logic        miss = (a[31:2] != BASE[31:2]);
    if (miss || b == 4'b0000) begin
      e = '0; e.o.busy = 1; e.o.ack = 1; e.o.err = miss; e.chk_rd = 1;
      push_exp(k, e);
      return 1;
    end
    for (int n = 0; n < 4; n++) begin
      if (b[n]) begin
        e = '0; e.o.busy = 1; e.o.dir = 2'(n); e.chk_dd = 1;
        e.o.data = w ? d[8*n +: 8] : 8'h00;
        push_exp(k, e); len++;
        e.o.wr = w; e.o.rd = !w;
        for (int j = 0; j < s; j++) begin push_exp(k, e); len++; end
        e.o.wr = 0; e.o.rd = 0;
        push_exp(k, e); len++;
        if (!w) rexp[8*n +: 8] = io_mem[k][n];
      end
    end
    e = '0; e.o.busy = 1; e.o.ack = 1; e.o.rdata = w ? 32'h0 : rexp; e.chk_rd = 1;
    push_exp(k, e);
    return len + 1;
  endfunction

  always @(negedge clk) begin
    obs_t a;
    exp_t e;
    bit   have;
    if (mon_en && rst_n) begin
      for (int k = 0; k < 2; k++) begin
        a = obs[k];
        have = 0;
        if (k == 0 && expq0.size() > 0) begin e = expq0.pop_front(); have = 1; end
        if (k == 1 && expq1.size() > 0) begin e = expq1.pop_front(); have = 1; end
        if (have) begin
          chk($sformatf("ctl%0d", k), {a.busy, a.wr, a.rd, a.ack, a.err},
              {e.o.busy, e.o.wr, e.o.rd, e.o.ack, e.o.err});
          if (e.chk_dd) chk($sformatf("dir_data%0d", k), {a.dir, a.data}, {e.o.dir, e.o.data});
          if (e.chk_rd) chk($sformatf("rdata%0d", k), a.rdata, e.o.rdata);
        end else begin
          chk($sformatf("idle_ctl%0d", k), {a.busy, a.wr, a.rd, a.ack, a.err}, 5'b0);
        end
        if (a.ack) begin ack_cyc[k] = cyc; ack_rdata[k] = a.rdata; ack_err[k] = a.err; end
        if (a.wr) begin wr_cnt[k]++; last_io[k] = {a.dir, a.data}; end
        if (a.rd) begin rd_cnt[k]++; rd_log[k] = (rd_log[k] << 2) | 32'(a.dir); end
      end
    end
  end

  // Called #1 after a rising edge with the addressed instance idle.
  task automatic do_txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input bit hold, input bit noise);
    int len;
    we[k] = w; addr[k] = a; wdata[k] = d; be[k] = b; req[k] = 1'b1;
    ack_cyc[k] = -100; wr_cnt[k] = 0; rd_cnt[k] = 0; rd_log[k] = '0;
    @(posedge clk); #1;
    acc_cyc[k] = cyc;
    len = push_model(k, w, a, d, b);
    for (int i = 0; i < len; i++) begin
      if (noise) begin
        req[k] = 1'($urandom); we[k] = 1'($urandom); addr[k] = BASE;
        wdata[k] = $urandom; be[k] = 4'($urandom);
      end else if (!hold) begin
        req[k] = 1'b0;
      end
      @(posedge clk); #1;
    end
    if (!hold) req[k] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required below 2000000", $time);
    $fatal(1);
  end

  initial begin
    int          k, prev_k, sel;
    bit          h, nz, prev_hold;
    logic [31:0] a;
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; we[i] = 0; addr[i] = '0; wdata[i] = '0; be[i] = '0;
      for (int n = 0; n < 4; n++) io_mem[i][n] = 8'h00;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_obs0", obs[0], 0);
    chk("reset_obs1", obs[1], 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Single-lane store
    do_txn(0, 1'b1, BASE, 32'h0000_A500, 4'b0010, 0, 0);
    chk("t2_latency", 64'(ack_cyc[0] - acc_cyc[0] + 1), 4);
    chk("t2_wr_count", 64'(wr_cnt[0]), 1);
    chk("t2_dir_data", last_io[0], {2'd1, 8'hA5});
    chk("t2_err", ack_err[0], 0);

    // Full-word load
    io_mem[0][0] = 8'h00; io_mem[0][1] = 8'h11; io_mem[0][2] = 8'h22; io_mem[0][3] = 8'h33;
    do_txn(0, 1'b0, BASE, 32'h0, 4'b1111, 0, 0);
    chk("t3_rdata", ack_rdata[0], 32'h3322_1100);
    chk("t3_latency", 64'(ack_cyc[0] - acc_cyc[0] + 1), 13);
    chk("t3_rd_order", rd_log[0], 32'h1B);

    // Address miss
    do_txn(0, 1'b1, BASE + 32'd4, 32'hDEAD_BEEF, 4'b1111, 0, 0);
    chk("t4_latency", 64'(ack_cyc[0] - acc_cyc[0] + 1), 1);
    chk("t4_err", ack_err[0], 1);
    chk("t4_strobes", 64'(wr_cnt[0] + rd_cnt[0]), 0);

    // Sparse load with 3-cycle strobes
    io_mem[1][0] = 8'h77; io_mem[1][1] = 8'h5A; io_mem[1][2] = 8'h77; io_mem[1][3] = 8'hC3;
    do_txn(1, 1'b0, BASE, 32'h0, 4'b1010, 0, 0);
    chk("t5_rdata", ack_rdata[1], 32'hC300_5A00);
    chk("t5_rd_count", 64'(rd_cnt[1]), 6);
    chk("t5_rd_order", rd_log[1], 32'h57F);
    chk("t5_latency", 64'(ack_cyc[1] - acc_cyc[1] + 1), 11);

    // req held across ack, then busy-time req pulses
    do_txn(0, 1'b1, BASE, 32'h4433_2211, 4'b0101, 1, 0);
    io_mem[0][1] = 8'h9C; io_mem[0][2] = 8'h3E;
    do_txn(0, 1'b0, BASE, 32'h0, 4'b0110, 0, 1);
    chk("t6_rdata", ack_rdata[0], 32'h003E_9C00);

    prev_k = 0; prev_hold = 0;
    for (int it = 0; it < 200; it++) begin
      k   = prev_hold ? prev_k : int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       a = BASE | 32'($urandom_range(0, 3));
      else if (sel == 7) a = BASE + 32'd4;
      else               a = $urandom;
      h  = (it < 199) && ($urandom_range(0, 3) == 0);
      nz = !h && ($urandom_range(0, 1) == 1);
      for (int n = 0; n < 4; n++) io_mem[k][n] = 8'($urandom);
      do_txn(k, 1'($urandom), a, $urandom, 4'($urandom), h, nz);
      prev_k = k; prev_hold = h;
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset during a strobe cycle on both instances
    mon_en = 1'b0;
    we[0] = 1'b1; addr[0] = BASE; wdata[0] = 32'h5555_5555; be[0] = 4'b0001; req[0] = 1'b1;
    we[1] = 1'b0; addr[1] = BASE; be[1] = 4'b0001; req[1] = 1'b1;
    @(posedge clk); #1;
    req[0] = 1'b0; req[1] = 1'b0;
    @(posedge clk); #1;
    chk("t1_pre_wr", bus0.io_wr_o, 1);
    chk("t1_pre_rd", bus1.io_rd_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_strobes", {bus0.io_wr_o, bus0.io_rd_o, bus1.io_wr_o, bus1.io_rd_o}, 0);
    chk("t1_rst_busy_ack", {bus0.busy_o, bus0.ack_o, bus1.busy_o, bus1.ack_o}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) io_mem[0][n] = 8'($urandom);
    do_txn(0, 1'b0, BASE, 32'h0, 4'b1111, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drain", 64'(expq0.size() + expq1.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
